// File: rtl/aes_round_ctrl_if.sv
// Handshake and data bundle between the GCM front end, key store,
// aes_round datapath and the round sequencer.
interface aes_round_ctrl_if #(
    parameter int RND_SIZE = 128,
    parameter int KIDX_W   = 4
);
    logic                i_in_vld;
    logic                o_in_rdy;
    logic [RND_SIZE-1:0] i_in_text;
    logic [1:0]          i_in_nr;
    logic                o_key_rd;
    logic [KIDX_W-1:0]   o_key_idx;
    logic [RND_SIZE-1:0] i_key;
    logic                o_rnd_vld;
    logic [RND_SIZE-1:0] o_rnd_text;
    logic [RND_SIZE-1:0] o_rnd_key;
    logic                o_lst_rnd;
    logic                i_rnd_vld;
    logic [RND_SIZE-1:0] i_rnd_text;
    logic                o_out_vld;
    logic                i_out_rdy;
    logic [RND_SIZE-1:0] o_out_text;
    logic                o_err;

    modport master (
        output i_in_vld, i_in_text, i_in_nr, i_key,
        output i_rnd_vld, i_rnd_text, i_out_rdy,
        input  o_in_rdy, o_key_rd, o_key_idx, o_rnd_vld,
        input  o_rnd_text, o_rnd_key, o_lst_rnd,
        input  o_out_vld, o_out_text, o_err
    );

    modport slave (
        input  i_in_vld, i_in_text, i_in_nr, i_key,
        input  i_rnd_vld, i_rnd_text, i_out_rdy,
        output o_in_rdy, o_key_rd, o_key_idx, o_rnd_vld,
        output o_rnd_text, o_rnd_key, o_lst_rnd,
        output o_out_vld, o_out_text, o_err
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES datapath: initial AddRoundKey,
// then Nr rounds with keys fetched by index, one block in flight.
module aes_round_ctrl #(
    parameter int RND_SIZE = 128,
    parameter int KIDX_W   = 4,
    parameter int TMO_CYC  = 255
) (
    input  logic            clk,
    input  logic            rst,
    aes_round_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE,
        KEY0,
        ISSUE,
        WAIT,
        DONE
    } state_e;

    localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

    state_e              st_q, st_d;
    logic [RND_SIZE-1:0] text_q, text_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          nr_q, nr_d;
    logic [15:0]         tmo_q, tmo_d;
    logic                err_q, err_d;

    logic                key_rd;
    logic [KIDX_W-1:0]   key_idx;
    logic                rnd_vld;
    logic                lst_rnd;

    // 0 -> 10, 1 -> 12, 2 -> 14 rounds
    function automatic logic [3:0] nr_of(input logic [1:0] k);
        return 4'd10 + {1'b0, k, 1'b0};
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q   <= IDLE;
            text_q <= '0;
            cnt_q  <= '0;
            nr_q   <= '0;
            tmo_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            text_q <= text_d;
            cnt_q  <= cnt_d;
            nr_q   <= nr_d;
            tmo_q  <= tmo_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        text_d  = text_q;
        cnt_d   = cnt_q;
        nr_d    = nr_q;
        tmo_d   = tmo_q;
        err_d   = 1'b0;
        key_rd  = 1'b0;
        key_idx = '0;
        rnd_vld = 1'b0;
        lst_rnd = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (bus.i_in_vld) begin
                    if (bus.i_in_nr == 2'd3) begin
                        err_d = 1'b1;
                    end else begin
                        text_d = bus.i_in_text;
                        nr_d   = nr_of(bus.i_in_nr);
                        key_rd = 1'b1;
                        st_d   = KEY0;
                    end
                end
            end
            KEY0: begin
                text_d  = text_q ^ bus.i_key;
                cnt_d   = 4'd1;
                key_rd  = 1'b1;
                key_idx = KIDX_W'(1);
                st_d    = ISSUE;
            end
            ISSUE: begin
                rnd_vld = 1'b1;
                lst_rnd = (cnt_q == nr_q);
                tmo_d   = '0;
                st_d    = WAIT;
            end
            WAIT: begin
                if (bus.i_rnd_vld) begin
                    text_d = bus.i_rnd_text;
                    if (cnt_q == nr_q) begin
                        st_d = DONE;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                        key_rd  = 1'b1;
                        key_idx = KIDX_W'(cnt_q + 4'd1);
                        st_d    = ISSUE;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    // datapath never answered: drop the block
                    err_d = 1'b1;
                    st_d  = IDLE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            DONE: begin
                if (bus.i_out_rdy) begin
                    st_d = IDLE;
                end
            end
            default: begin
                st_d = IDLE;
            end
        endcase
    end

    assign bus.o_in_rdy   = (st_q == IDLE);
    assign bus.o_key_rd   = key_rd;
    assign bus.o_key_idx  = key_idx;
    assign bus.o_rnd_vld  = rnd_vld;
    assign bus.o_rnd_text = rnd_vld ? text_q : '0;
    assign bus.o_rnd_key  = rnd_vld ? bus.i_key : '0;
    assign bus.o_lst_rnd  = lst_rnd;
    assign bus.o_out_vld  = (st_q == DONE);
    assign bus.o_out_text = text_q;
    assign bus.o_err      = err_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES round
// datapath and key store built from the FIPS-197 example keys.
module tb_aes_round_ctrl;
    logic clk = 1'b0;
    logic rst;

    aes_round_ctrl_if #(.RND_SIZE(128), .KIDX_W(4)) bus ();

    aes_round_ctrl #(
        .RND_SIZE(128),
        .KIDX_W  (4),
        .TMO_CYC (8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT3 = 128'h8ea2b7ca516745bfeafc49904b496089;

    int nvec = 0;
    int nmis = 0;

    logic [7:0]   sbox [256];
    logic [127:0] rk [15];

    int           cyc = 0;
    int           lat = 1;
    bit           dp_mute = 1'b0;
    bit           spur = 1'b0;
    int           dp_wait = 0;
    logic [127:0] dp_res = '0;
    bit           kpend = 1'b0;
    logic [3:0]   kidx_s = '0;
    int           kexp = 0;
    int nkr = 0, kbad = 0, nrv = 0, nlst = 0, lst_at = 0, nout = 0, nerrp = 0;
    int b_kr, b_bad, b_rv, b_lst, b_out, b_err;
    int acc;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sb_gen(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int i = 0; i < 254; i++) v = gm(v, a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] w);
        return {sbox[w[31:24]], sbox[w[23:16]], sbox[w[15:8]], sbox[w[7:0]]};
    endfunction

    function automatic logic [127:0] aes_rnd(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic lst);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox[s[127-8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[4*c+r] = b[4*((c+r)%4)+r];
        if (!lst) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c];
                a1 = t[4*c+1];
                a2 = t[4*c+2];
                a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o ^ k;
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = sw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++)
            rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // key store, datapath and monitor
    initial begin
        bus.i_key      = '0;
        bus.i_rnd_vld  = 1'b0;
        bus.i_rnd_text = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            bus.i_rnd_vld = spur;
            if (rst) begin
                dp_wait = 0;
            end else if (dp_wait > 0) begin
                dp_wait--;
                if (dp_wait == 0 && !dp_mute) begin
                    bus.i_rnd_vld  = 1'b1;
                    bus.i_rnd_text = dp_res;
                end
            end
            if (kpend) bus.i_key = rk[kidx_s];
            @(negedge clk);
            #1;
            kpend  = bus.o_key_rd;
            kidx_s = bus.o_key_idx;
            if (bus.o_key_rd) begin
                nkr++;
                if (bus.o_in_rdy) kexp = 0;
                if (int'(bus.o_key_idx) != kexp) kbad++;
                kexp++;
            end
            if (bus.o_rnd_vld) begin
                nrv++;
                if (bus.o_lst_rnd) begin
                    nlst++;
                    lst_at = nrv;
                end
                dp_res  = aes_rnd(bus.o_rnd_text, bus.o_rnd_key, bus.o_lst_rnd);
                dp_wait = lat;
            end
            if (bus.o_err) nerrp++;
            if (bus.o_out_vld) nout++;
        end
    end

    task automatic snap();
        b_kr  = nkr;
        b_bad = kbad;
        b_rv  = nrv;
        b_lst = nlst;
        b_out = nout;
        b_err = nerrp;
    endtask

    task automatic send(input logic [127:0] pt, input logic [1:0] nr);
        snap();
        bus.i_in_vld  = 1'b1;
        bus.i_in_text = pt;
        bus.i_in_nr   = nr;
        acc = cyc;
        @(negedge clk);
        bus.i_in_vld = 1'b0;
    endtask

    task automatic finish(input int exp_lat, input logic [127:0] ct,
                          input int nr_n, input bit hs);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            ok = bus.o_out_vld;
        end
        check("out_seen", 128'(ok), 128'(1));
        check("latency", 128'(cyc - acc), 128'(exp_lat));
        check("cipher", bus.o_out_text, ct);
        check("key_reads", 128'(nkr - b_kr), 128'(nr_n + 1));
        check("key_order", 128'(kbad - b_bad), 128'(0));
        check("rounds", 128'(nrv - b_rv), 128'(nr_n));
        check("lst_cnt", 128'(nlst - b_lst), 128'(1));
        check("lst_pos", 128'(lst_at - b_rv), 128'(nr_n));
        check("no_err", 128'(nerrp - b_err), 128'(0));
        if (hs) begin
            bus.i_out_rdy = 1'b1;
            @(negedge clk);
            bus.i_out_rdy = 1'b0;
            check("rdy_after", 128'(bus.o_in_rdy), 128'(1));
            check("vld_drop", 128'(bus.o_out_vld), 128'(0));
        end
    endtask

    task automatic rst_outs(input string tag);
        check(tag, {122'h0, bus.o_in_rdy, bus.o_key_rd, bus.o_rnd_vld,
                    bus.o_lst_rnd, bus.o_out_vld, bus.o_err}, 128'h20);
        check({tag, "_txt"}, bus.o_out_text | bus.o_rnd_text | bus.o_rnd_key, '0);
    endtask

    initial begin
        bit ok;
        rst           = 1'b1;
        bus.i_in_vld  = 1'b0;
        bus.i_in_text = '0;
        bus.i_in_nr   = '0;
        bus.i_out_rdy = 1'b0;
        for (int i = 0; i < 256; i++) sbox[i] = sb_gen(8'(i));
        repeat (3) @(negedge clk);
        rst_outs("reset");
        rst = 1'b0;
        @(negedge clk);

        // FIPS-197 C.1, L=1
        expand(K1, 4, 10);
        lat = 1;
        send(PT, 2'd0);
        finish(22, CT1, 10, 1'b1);

        // FIPS-197 C.3, L=3
        expand(K3, 8, 14);
        lat = 3;
        send(PT, 2'd2);
        finish(58, CT3, 14, 1'b1);

        // illegal key size
        snap();
        bus.i_in_vld = 1'b1;
        bus.i_in_nr  = 2'd3;
        @(negedge clk);
        bus.i_in_vld = 1'b0;
        check("nr3_err", 128'(bus.o_err), 128'(1));
        check("nr3_rdy", 128'(bus.o_in_rdy), 128'(1));
        @(negedge clk);
        check("nr3_pulse", 128'(bus.o_err), 128'(0));
        check("nr3_nokey", 128'(nkr - b_kr), 128'(0));
        check("nr3_errs", 128'(nerrp - b_err), 128'(1));

        // silent datapath -> timeout
        expand(K1, 4, 10);
        dp_mute = 1'b1;
        send(PT, 2'd0);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = bus.o_err;
        end
        check("tmo_seen", 128'(ok), 128'(1));
        check("tmo_cyc", 128'(cyc - acc), 128'(11));
        check("tmo_idle", 128'(bus.o_in_rdy), 128'(1));
        @(negedge clk);
        check("tmo_pulse", 128'(bus.o_err), 128'(0));
        check("tmo_noout", 128'(nout - b_out), 128'(0));
        dp_mute = 1'b0;
        repeat (4) @(negedge clk);

        // DONE backpressure with spurious inputs, then back-to-back block
        lat = 2;
        send(PT, 2'd0);
        finish(32, CT1, 10, 1'b0);
        b_err = nerrp;
        for (int i = 0; i < 5; i++) begin
            bus.i_in_vld  = 1'b1;
            bus.i_in_nr   = 2'd3;
            bus.i_in_text = '1;
            spur          = 1'b1;
            @(negedge clk);
            check("hold_vld", 128'(bus.o_out_vld), 128'(1));
            check("hold_txt", bus.o_out_text, CT1);
        end
        check("hold_noerr", 128'(nerrp - b_err), 128'(0));
        spur          = 1'b0;
        bus.i_in_nr   = 2'd0;
        bus.i_in_text = PT;
        bus.i_out_rdy = 1'b1;
        @(negedge clk);
        bus.i_out_rdy = 1'b0;
        check("b2b_rdy", 128'(bus.o_in_rdy), 128'(1));
        snap();
        acc = cyc;
        @(negedge clk);
        bus.i_in_vld = 1'b0;
        finish(32, CT1, 10, 1'b1);

        // reset during round 4, then a clean block
        lat = 1;
        send(PT, 2'd0);
        for (int i = 0; i < 50 && cyc < acc + 9; i++) @(negedge clk);
        rst = 1'b1;
        #1;
        rst_outs("mid_rst");
        @(negedge clk);
        rst_outs("mid_rst_hold");
        rst = 1'b0;
        @(negedge clk);
        send(PT, 2'd0);
        finish(22, CT1, 10, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
